memory_bus_router: RTL and testbench
====================================

// Module: memory_bus_router
// PURPOSE
//  Parametrised successor to the fixed 4-bank memory bus. Decodes CPU address into one of
//  NUM_BANKS banks and adds a ready/wait-state handshake, so slow banks (SPI EEPROM, SPI RAM)
//  can stall the CPU. Sits between the CPU core and the rom/ram/peripherals instances.
//  Data returns through a registered mux. Unmapped banks report bus_error.
// PARAMETERS
//  ADDR_W        16       CPU address width
//  DATA_W        16       data width
//  BANK_SEL_W    2        bank-select field width; NUM_BANKS = 1<<BANK_SEL_W
//  BANK_SEL_LSB  13       LSB of bank-select field in address
//  BANK_ADDR_W   11       address bits forwarded to banks (address[BANK_ADDR_W-1:0])
//  BANK_MAP      4'b1111  bit i=1: bank i is populated
//  TIMEOUT_CYCLES 255     ACCESS cycles before abort (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk               in  1                   system clock
//  reset             in  1                   synchronous, active-high reset
//  address           in  ADDR_W              CPU address, held stable while request pending
//  data_in           in  DATA_W              CPU write data
//  data_out          out DATA_W              registered read data
//  bus_enable        in  1                   CPU request strobe
//  write_enable      in  1                   1=write, 0=read; sampled with bus_enable
//  ready             out 1                   one-cycle completion pulse
//  bus_error         out 1                   valid with ready; unmapped bank or timeout
//  bank_select       out NUM_BANKS           one-hot bank enable during ACCESS
//  bank_address      out BANK_ADDR_W         latched bank-local address
//  bank_data_in      out DATA_W              latched write data to banks
//  bank_write_enable out NUM_BANKS           one-hot write strobe during write ACCESS
//  bank_data_out     in  NUM_BANKS*DATA_W    flattened bank read data, bank i at [i*DATA_W +: DATA_W]
//  bank_ready        in  NUM_BANKS           per-bank completion, sampled only for selected bank
// BEHAVIOUR
//  Reset: state=IDLE; data_out=0, ready=0, bus_error=0, bank_select=0, bank_write_enable=0,
//   bank_address=0, bank_data_in=0. Reset mid-ACCESS aborts at once; no ready pulse is issued.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: on bus_enable=1, latch address, data_in, write_enable and sel=address[BANK_SEL_LSB +: BANK_SEL_W].
//   If BANK_MAP[sel]=0, go to DONE with bus_error=1, data_out=0. Otherwise go to ACCESS.
//  ACCESS: bank_select[sel]=1; bank_write_enable[sel]=latched write_enable; all other bits 0.
//   On bank_ready[sel]=1: for a read, data_out <= bank_data_out[sel]; for a write, data_out is unchanged.
//   Then go to DONE. A bank commits a write exactly once, in the cycle it asserts bank_ready.
//  DONE: ready=1 for exactly one cycle; bank_select=0; back to IDLE. bus_error holds its value
//   for this cycle only.
//  Latency: request sampled at edge N; with a zero-wait bank (bank_ready tied 1), ready=1 in
//   cycle N+2. Each wait cycle adds 1.
//  A new request is accepted only in IDLE. If bus_enable is still high in the cycle after
//   DONE, that starts a new transaction. Dropping bus_enable during ACCESS does not abort it.
//  bank_ready of non-selected banks is ignored. data_out holds its value between transactions.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: an 8..16-bit counter clears on entry to ACCESS and increments
//   each ACCESS cycle. When it reaches TIMEOUT_CYCLES with no bank_ready, go to DONE with
//   bus_error=1 and data_out=0, and drop bank strobes. bank_ready seen in the same cycle
//   wins over the timeout.
//  BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely. TIMEOUT_CYCLES is ignored.
// STRUCTURE
//  Package memory_bus_pkg holds:
//   - state typedef (IDLE, ACCESS, DONE)
//   - default width constants
//   - a helper function returning the one-hot vector for sel
//  Sub-module memory_bus_timeout: counter with clear/enable/expired.
//   It is instantiated only under BUS_TIMEOUT_EN.
//  Decode and read mux stay inline.
// TESTING
//  1 Read bank 1 at 0x2005, bank_ready tied 1, bank1 data 0xBEEF
//    -> bank_address=0x005, ready in cycle N+2, data_out=0xBEEF, bus_error=0.
//  2 Write 0x1234 to 0x0010, bank0 ready delayed 3 cycles
//    -> bank_write_enable=4'b0001 for 4 cycles, ready at N+5, data_out unchanged.
//  3 BANK_MAP=4'b0111, read 0x6000 -> no bank_select, ready at N+1, bus_error=1, data_out=0.
//  4 Assert reset during ACCESS -> next cycle all outputs 0, no ready.
//    Next request completes normally.
//  5 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, bank2 never ready
//    -> ready+bus_error after 8 ACCESS cycles, data_out=0.
//    Same test without the macro: still waiting after 100 cycles.
//  6 Back-to-back: bus_enable held high across two reads
//    -> two ready pulses, 3 cycles apart, each with correct data.
//    Non-selected bank_ready toggling has no effect.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// Shared types and defaults for the banked memory bus router.
// Holds the FSM state type, default widths and the bank one-hot helper.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } bus_state_e;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_BANK_SEL_W   = 2;
    localparam int DEF_BANK_SEL_LSB = 13;
    localparam int DEF_BANK_ADDR_W  = 11;
    localparam int DEF_TIMEOUT      = 255;
    localparam int TIMEOUT_W        = 16;

    function automatic logic [31:0] bank_onehot(input logic [31:0] sel);
        return 32'd1 << sel;
    endfunction

endpackage

// File: rtl/memory_bus_timeout.sv
// ACCESS-phase watchdog: counts while enabled, flags the final allowed cycle.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module memory_bus_timeout
    import memory_bus_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    // expired is raised in the LIMIT-th enabled cycle so the caller leaves on that edge
    assign expired = enable && (count == TIMEOUT_W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/memory_bus_router.sv
// Banked CPU memory bus with ready/wait-state handshake and bus_error for unmapped banks.
// Optional ACCESS timeout is built in when BUS_TIMEOUT_EN is defined.
module memory_bus_router
    import memory_bus_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BANK_SEL_W     = DEF_BANK_SEL_W,
    parameter int BANK_SEL_LSB   = DEF_BANK_SEL_LSB,
    parameter int BANK_ADDR_W    = DEF_BANK_ADDR_W,
    parameter logic [(1<<BANK_SEL_W)-1:0] BANK_MAP = '1,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [DATA_W-1:0]                 data_in,
    output logic [DATA_W-1:0]                 data_out,
    input  logic                              bus_enable,
    input  logic                              write_enable,
    output logic                              ready,
    output logic                              bus_error,
    output logic [(1<<BANK_SEL_W)-1:0]        bank_select,
    output logic [BANK_ADDR_W-1:0]            bank_address,
    output logic [DATA_W-1:0]                 bank_data_in,
    output logic [(1<<BANK_SEL_W)-1:0]        bank_write_enable,
    input  logic [(1<<BANK_SEL_W)*DATA_W-1:0] bank_data_out,
    input  logic [(1<<BANK_SEL_W)-1:0]        bank_ready
);

    localparam int NUM_BANKS = 1 << BANK_SEL_W;

    bus_state_e state_q;
    bus_state_e state_d;

    logic [BANK_SEL_W-1:0] sel_in;
    logic [BANK_SEL_W-1:0] sel_q;
    logic                  we_q;
    logic                  mapped;
    logic                  sel_ready;
    logic                  timeout_hit;
    logic [NUM_BANKS-1:0]  sel_oh;
    logic [DATA_W-1:0]     rd_data;
    logic                  unused_addr_bits;

    assign sel_in    = address[BANK_SEL_LSB +: BANK_SEL_W];
    assign mapped    = BANK_MAP[sel_in];
    assign sel_ready = bank_ready[sel_q];
    assign sel_oh    = NUM_BANKS'(bank_onehot(32'(sel_q)));
    assign rd_data   = bank_data_out[sel_q*DATA_W +: DATA_W];

    assign unused_addr_bits = ^address;

`ifdef BUS_TIMEOUT_EN
    memory_bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ACCESS),
        .enable  (state_q == ACCESS),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus_enable) begin
                    state_d = mapped ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (sel_ready || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready             = 1'b0;
        bank_select       = '0;
        bank_write_enable = '0;
        unique case (state_q)
            ACCESS: begin
                bank_select = sel_oh;
                if (we_q) begin
                    bank_write_enable = sel_oh;
                end
            end
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end

    // Request latch, completion data and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= '0;
            we_q         <= 1'b0;
            bank_address <= '0;
            bank_data_in <= '0;
            data_out     <= '0;
            bus_error    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus_enable) begin
                        sel_q        <= sel_in;
                        we_q         <= write_enable;
                        bank_address <= address[BANK_ADDR_W-1:0];
                        bank_data_in <= data_in;
                        bus_error    <= !mapped;
                        if (!mapped) begin
                            data_out <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        bus_error <= 1'b0;
                        if (!we_q) begin
                            data_out <= rd_data;
                        end
                    end else if (timeout_hit) begin
                        bus_error <= 1'b1;
                        data_out  <= '0;
                    end
                end
                DONE:    bus_error <= 1'b0;
                default: bus_error <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_router.sv
// Scoreboard bench for memory_bus_router with behavioural wait-state banks.
// Build with BUS_TIMEOUT_EN defined to exercise the timeout path.
module tb_memory_bus_router;

    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        bus_enable;
    logic        write_enable;
    logic        ready;
    logic        bus_error;
    logic [3:0]  bank_select;
    logic [10:0] bank_address;
    logic [15:0] bank_data_in;
    logic [3:0]  bank_write_enable;
    logic [63:0] bank_data_out;
    logic [3:0]  bank_ready;

    always #5 clk = ~clk;

    memory_bus_router #(
        .BANK_MAP       (4'b0111),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .address           (address),
        .data_in           (data_in),
        .data_out          (data_out),
        .bus_enable        (bus_enable),
        .write_enable      (write_enable),
        .ready             (ready),
        .bus_error         (bus_error),
        .bank_select       (bank_select),
        .bank_address      (bank_address),
        .bank_data_in      (bank_data_in),
        .bank_write_enable (bank_write_enable),
        .bank_data_out     (bank_data_out),
        .bank_ready        (bank_ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: per-bank wait states, noisy ready when not selected
    logic [15:0] mem [4][2048];
    int          wait_cfg [4];
    int          bcnt [4];
    logic [3:0]  noise;
    logic        ld_en = 1'b0;
    int          ld_b;
    logic [10:0] ld_a;
    logic [15:0] ld_d;

    always @(posedge clk) begin
        noise <= reset ? 4'b0101 : ~noise;
        if (ld_en) mem[ld_b][ld_a] <= ld_d;
        for (int b = 0; b < 4; b++) begin
            bcnt[b] <= bank_select[b] ? bcnt[b] + 1 : 0;
            if (bank_write_enable[b] && bank_ready[b])
                mem[b][bank_address] <= bank_data_in;
        end
    end

    always_comb begin
        bank_ready    = '0;
        bank_data_out = '0;
        for (int b = 0; b < 4; b++) begin
            bank_data_out[b*16 +: 16] = mem[b][bank_address];
            if (bank_select[b])
                bank_ready[b] = (wait_cfg[b] != NEVER) && (bcnt[b] >= wait_cfg[b]);
            else
                bank_ready[b] = noise[b];
        end
    end

    typedef struct {
        string       tag;
        logic [15:0] data;
        logic        err;
        int          due;
        int          sel_cyc;
        logic [3:0]  sel_oh;
        logic [3:0]  we_oh;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] exp_last = 16'h0;

    int         sel_cycles = 0;
    logic [3:0] sel_or = 4'h0;
    logic [3:0] we_or = 4'h0;

    always @(negedge clk) begin
        if (reset) begin
            sel_cycles = 0;
            sel_or     = 4'h0;
            we_or      = 4'h0;
        end else begin
            if (bank_select != 4'h0) begin
                sel_cycles++;
                sel_or |= bank_select;
            end
            we_or |= bank_write_enable;
            if (ready) begin
                if (sbq.size() == 0) begin
                    check("spurious_ready", 32'(ready), 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check({e.tag, ".data"}, 32'(data_out), 32'(e.data));
                    check({e.tag, ".err"}, 32'(bus_error), 32'(e.err));
                    check({e.tag, ".cyc"}, cyc, e.due);
                    check({e.tag, ".selcyc"}, sel_cycles, e.sel_cyc);
                    check({e.tag, ".sel"}, 32'(sel_or), 32'(e.sel_oh));
                    check({e.tag, ".we"}, 32'(we_or), 32'(e.we_oh));
                end
                sel_cycles = 0;
                sel_or     = 4'h0;
                we_or      = 4'h0;
            end
        end
    end

    function automatic exp_t mk(input string tag, input logic [15:0] d,
                                input logic err, input int due, input int sc,
                                input logic [3:0] oh, input logic we);
        exp_t e;
        e.tag     = tag;
        e.data    = d;
        e.err     = err;
        e.due     = due;
        e.sel_cyc = sc;
        e.sel_oh  = oh;
        e.we_oh   = we ? oh : 4'h0;
        return e;
    endfunction

    task automatic load(input int b, input logic [10:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_b  = b;
        ld_a  = a;
        ld_d  = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic req(input string tag, input logic [15:0] a, input logic [15:0] d,
                       input logic we, input logic [15:0] exp_d, input logic exp_err,
                       input int lat, input int sc, input logic [3:0] oh);
        logic [15:0] ed;
        @(negedge clk);
        address      = a;
        data_in      = d;
        write_enable = we;
        bus_enable   = 1'b1;
        @(posedge clk);
        #1;
        bus_enable = 1'b0;
        ed = (we && !exp_err) ? exp_last : exp_d;
        exp_last = ed;
        sbq.push_back(mk(tag, ed, exp_err, cyc + lat - 1, sc, oh, we));
    endtask

    task automatic wait_ready(input string tag, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        check({tag, ".ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset        = 1'b1;
        address      = '0;
        data_in      = '0;
        bus_enable   = 1'b0;
        write_enable = 1'b0;
        for (int b = 0; b < 4; b++) wait_cfg[b] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.ready", 32'(ready), 0);
        check("rst.err", 32'(bus_error), 0);
        check("rst.data", 32'(data_out), 0);
        check("rst.sel", 32'(bank_select), 0);
        check("rst.we", 32'(bank_write_enable), 0);
        check("rst.baddr", 32'(bank_address), 0);
        check("rst.bdin", 32'(bank_data_in), 0);
        reset = 1'b0;

        load(1, 11'h005, 16'hBEEF);
        load(1, 11'h007, 16'hA5A5);
        load(0, 11'h020, 16'h5A5A);

        req("t1", 16'h2005, 16'h0, 1'b0, 16'hBEEF, 1'b0, 2, 1, 4'b0010);
        check("t1.baddr", 32'(bank_address), 32'h005);
        wait_ready("t1", 10);

        wait_cfg[0] = 3;
        req("t2w", 16'h0010, 16'h1234, 1'b1, 16'h0, 1'b0, 5, 4, 4'b0001);
        check("t2w.bdin", 32'(bank_data_in), 32'h1234);
        wait_ready("t2w", 10);
        req("t2r", 16'h0010, 16'h0, 1'b0, 16'h1234, 1'b0, 5, 4, 4'b0001);
        wait_ready("t2r", 10);
        wait_cfg[0] = 0;

        req("t3", 16'h6000, 16'h0, 1'b0, 16'h0, 1'b1, 1, 0, 4'b0000);
        wait_ready("t3", 10);

        begin
            int d1;
            @(negedge clk);
            address      = 16'h2007;
            write_enable = 1'b0;
            bus_enable   = 1'b1;
            @(posedge clk);
            #1;
            sbq.push_back(mk("t6a", 16'hA5A5, 1'b0, cyc + 1, 1, 4'b0010, 1'b0));
            wait_ready("t6a", 10);
            d1 = cyc;
            address = 16'h0020;
            sbq.push_back(mk("t6b", 16'h5A5A, 1'b0, d1 + 3, 1, 4'b0001, 1'b0));
            @(posedge clk);
            @(posedge clk);
            #1 bus_enable = 1'b0;
            wait_ready("t6b", 10);
            exp_last = 16'h5A5A;
        end

        wait_cfg[0] = 20;
        @(negedge clk);
        address    = 16'h0030;
        bus_enable = 1'b1;
        @(posedge clk);
        #1 bus_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("t4.insel", 32'(bank_select), 32'h1);
        pulse_reset();
        check("t4.ready", 32'(ready), 0);
        check("t4.sel", 32'(bank_select), 0);
        check("t4.err", 32'(bus_error), 0);
        check("t4.data", 32'(data_out), 0);
        check("t4.baddr", 32'(bank_address), 0);
        reset = 1'b0;
        exp_last = 16'h0;
        wait_cfg[0] = 0;
        repeat (3) @(negedge clk);
        req("t4n", 16'h2005, 16'h0, 1'b0, 16'hBEEF, 1'b0, 2, 1, 4'b0010);
        wait_ready("t4n", 10);

        wait_cfg[2] = NEVER;
`ifdef BUS_TIMEOUT_EN
        req("t5", 16'h4000, 16'h0, 1'b0, 16'h0, 1'b1, 9, 8, 4'b0100);
        wait_ready("t5", 20);
`else
        @(negedge clk);
        address    = 16'h4000;
        bus_enable = 1'b1;
        @(posedge clk);
        #1 bus_enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        check("t5.noready", seen, 0);
        check("t5.sel", 32'(bank_select), 32'h4);
        pulse_reset();
        reset = 1'b0;
        exp_last = 16'h0;
`endif
        wait_cfg[2] = 0;

        repeat (5) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
